// File: rtl/decoder_pkg.sv
// Shared types for the registered N-to-2^N decoder: transaction modes and FSM states.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERM  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_CLEAR  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        SCAN = 2'b10
    } state_e;

endpackage

// File: rtl/decoder_seq_onehot.sv
// Combinational N -> 2^N one-hot shift decoder.
module dec_onehot #(
    parameter int N = 4
) (
    input  logic [N-1:0]        code,
    output logic [(1<<N)-1:0]   onehot
);
    localparam int OUT_W = 1 << N;

    assign onehot = OUT_W'(1) << code;

endmodule

// File: rtl/decoder_seq.sv
// Registered N-to-2^N decoder with valid/ready intake, global enable and
// one-hot / thermometer / auto-scan output modes.
module decoder_seq
    import decoder_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int DWELL_W = 8,
    localparam int OUT_W   = 1 << N
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_code,
    input  logic [1:0]         in_mode,
    input  logic [DWELL_W-1:0] in_dwell,
    output logic [OUT_W-1:0]   F,
    output logic               out_valid,
    output logic               scan_wrap
);

    state_e             state_q, state_d;
    logic [N-1:0]       idx_q, idx_d, idx_inc, scan_sel;
    logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
    logic [OUT_W-1:0]   hold_q, hold_d, f_d;
    logic [OUT_W-1:0]   code_oh, scan_oh, therm;
    logic               wrap_d, accept;

    assign in_ready = en;
    assign accept   = in_valid & en;
    assign idx_inc  = idx_q + 1'b1;
    // Decode whichever index will be current after this edge.
    assign scan_sel = (cnt_q == '0) ? idx_inc : idx_q;

    dec_onehot #(.N(N)) u_code_dec (.code(in_code),  .onehot(code_oh));
    dec_onehot #(.N(N)) u_scan_dec (.code(scan_sel), .onehot(scan_oh));

    always_comb begin
        therm = '0;
        for (int i = 0; i < OUT_W; i++) therm[i] = (in_code >= N'(i));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        f_d     = '0;
        wrap_d  = 1'b0;
        if (!en) begin
            f_d = '0;
        end else if (accept) begin
            case (mode_e'(in_mode))
                MODE_ONEHOT: begin state_d = HOLD; hold_d = code_oh; f_d = code_oh; end
                MODE_THERM:  begin state_d = HOLD; hold_d = therm;   f_d = therm;   end
                MODE_SCAN: begin
                    state_d = SCAN;
                    idx_d   = in_code;
                    dwell_d = in_dwell;
                    cnt_d   = in_dwell;
                    f_d     = code_oh;
                end
                default: begin state_d = IDLE; f_d = '0; end
            endcase
        end else begin
            case (state_q)
                HOLD: f_d = hold_q;
                SCAN: begin
                    f_d = scan_oh;
                    if (cnt_q == '0) begin
                        idx_d  = idx_inc;
                        cnt_d  = dwell_q;
                        wrap_d = (idx_inc == '0);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: f_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            dwell_q   <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            F         <= '0;
            out_valid <= 1'b0;
            scan_wrap <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dwell_q   <= dwell_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            F         <= f_d;
            out_valid <= (state_d != IDLE);
            scan_wrap <= wrap_d;
        end
    end

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq: driver pushes model predictions, monitor
// pops and compares one entry per cycle.
module tb_decoder_seq;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int OW = 16;

    logic          clk = 1'b0;
    logic          rst, en, in_valid, in_ready;
    logic [N-1:0]  in_code;
    logic [1:0]    in_mode;
    logic [DW-1:0] in_dwell;
    logic [OW-1:0] F;
    logic          out_valid, scan_wrap;

    always #5 clk = ~clk;

    decoder_seq #(.N(N), .DWELL_W(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_mode(in_mode), .in_dwell(in_dwell),
        .F(F), .out_valid(out_valid), .scan_wrap(scan_wrap)
    );

    typedef struct packed {
        logic [OW-1:0] f;
        logic          v;
        logic          w;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: 0 idle, 1 holding a fixed pattern, 2 scanning.
    int m_st = 0, m_val = 0, m_idx = 0, m_dw = 0, m_left = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("F", int'(F), int'(e.f));
            chk("out_valid", int'(out_valid), int'(e.v));
            chk("scan_wrap", int'(scan_wrap), int'(e.w));
        end
    end

    task automatic step(input bit r, input bit e, input bit v,
                        input int md, input int c, input int d);
        exp_t x;
        int   ef;
        bit   ew;
        rst = r; en = e; in_valid = v;
        in_mode = md[1:0]; in_code = c[N-1:0]; in_dwell = d[DW-1:0];
        #1;
        chk("in_ready", int'(in_ready), int'(e));
        ef = 0; ew = 0;
        if (r) begin
            m_st = 0; m_val = 0; m_idx = 0; m_dw = 0; m_left = 0;
        end else if (!e) begin
            ef = 0;
        end else if (v) begin
            case (md)
                0: begin m_st = 1; m_val = 1 << c; ef = m_val; end
                1: begin m_st = 1; m_val = (1 << (c + 1)) - 1; ef = m_val; end
                2: begin m_st = 2; m_idx = c; m_dw = d; m_left = d; ef = 1 << c; end
                default: begin m_st = 0; ef = 0; end
            endcase
        end else if (m_st == 1) begin
            ef = m_val;
        end else if (m_st == 2) begin
            if (m_left == 0) begin
                m_idx  = (m_idx + 1) % OW;
                m_left = m_dw;
                ew     = (m_idx == 0);
            end else begin
                m_left = m_left - 1;
            end
            ef = 1 << m_idx;
        end
        x.f = ef[OW-1:0];
        x.v = (m_st != 0);
        x.w = ew;
        q.push_back(x);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        // reset, then a held one-hot
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 2, 3, 1);
        step(0, 1, 1, 0, 5, 0);
        idle(10);
        // thermometer edges
        step(0, 1, 1, 1, 0, 0);  idle(1);
        step(0, 1, 1, 1, 7, 0);  idle(1);
        step(0, 1, 1, 1, 15, 0); idle(1);
        // scan across the wrap, dwell 2 then dwell 0
        step(0, 1, 1, 2, 14, 2); idle(9);
        step(0, 1, 1, 2, 14, 0); idle(4);
        // enable freeze mid-dwell with a request that must be ignored
        step(0, 1, 1, 2, 3, 3);  idle(2);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 9, 0);
        idle(8);
        // pre-emption then clear
        step(0, 1, 1, 2, 0, 1);  idle(3);
        step(0, 1, 1, 0, 3, 0);  idle(4);
        step(0, 1, 1, 3, 0, 0);  idle(2);
        // reset on an advance edge discards the concurrent accept
        step(0, 1, 1, 2, 15, 0); idle(1);
        step(1, 1, 1, 0, 9, 0);  idle(2);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 99) < 25), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, OW - 1)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised, registered N-to-2^N decoder; successor to the fixed 2:4 and 4:16 combinational decoders.
- Adds a valid/ready input handshake, a global enable and three output modes: one-hot, thermometer and auto-scan.
- In auto-scan, a one-hot select walks across all outputs with a programmable dwell.
- Drives channel/row selects for downstream mux and strobe logic, with one registered stage of latency.

Parameters:
- N, 4, input code width; output width OUT_W = 2^N (derived localparam, not overridable).
- DWELL_W, 8, width of the scan dwell count.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; 0 blanks F and freezes internal state.
- in_valid  in  1  transaction request.
- in_ready  out  1  transaction accept; equals en (combinational).
- in_code  in  N  code or scan start index.
- in_mode  in  2  00 one-hot, 01 thermometer, 10 scan, 11 clear.
- in_dwell  in  DWELL_W  scan dwell; each output is held in_dwell+1 cycles.
- F  out  OUT_W  registered decoded output.
- out_valid  out  1  registered; 1 when state is not IDLE.
- scan_wrap  out  1  registered 1-cycle pulse when the scan index wraps from OUT_W-1 to 0.

Behaviour:
- Accept = in_valid & in_ready, sampled at the rising edge.
- Reset (rst=1 at an edge, from any state, including mid-scan):
  - state=IDLE, F=0, out_valid=0, scan_wrap=0.
  - Latched code, index, dwell and dwell counter all reset to 0.
- States: IDLE, HOLD, SCAN.
- On accept, the mode is applied at that edge and F reflects the new value in the following cycle (1-cycle latency):
  - 00 -> HOLD; F = one-hot, bit in_code set.
  - 01 -> HOLD; F[i] = 1 for every i <= in_code. Code 0 gives 0x0001; code OUT_W-1 gives all ones, with no overflow.
  - 10 -> SCAN; idx = in_code, F = one-hot(in_code); dwell latched, dwell_cnt = in_dwell.
  - 11 -> IDLE; F = 0.
- HOLD: F stays constant until the next accept or reset. No auto-clear.
- SCAN, with en=1 and no accept, each edge:
  - If dwell_cnt == 0: idx = idx+1 modulo OUT_W, dwell_cnt reloads with the latched dwell, and F follows the new idx.
  - Otherwise: dwell_cnt decrements.
  - With dwell 0, the index advances every cycle.
  - scan_wrap = 1 for exactly the cycle after the edge where idx goes OUT_W-1 -> 0; 0 otherwise.
- An accept while in HOLD or SCAN takes priority over the scan advance. The new transaction fully replaces the old one and restarts the dwell count.
- en=0:
  - in_ready=0, so no accept is possible.
  - F is registered to 0 at the next edge; scan_wrap=0.
  - state, idx and dwell_cnt are frozen; out_valid keeps its state-derived value.
- en returning to 1: at the first edge, F is recomputed from the frozen state (HOLD value, or one-hot(idx) in SCAN). The scan resumes with the frozen dwell_cnt.
- rst has priority over en, and en has priority over accept.
- F is always exactly one-hot in one-hot and SCAN modes, and all-zero in IDLE.
- in_code is unsigned. in_dwell is latched only on a scan accept; later changes are ignored.

Decomposition:
- Package decoder_pkg:
  - mode enum (MODE_ONEHOT=2'b00, MODE_THERM=2'b01, MODE_SCAN=2'b10, MODE_CLEAR=2'b11).
  - state enum (IDLE, HOLD, SCAN).
- Sub-module dec_onehot:
  - combinational N -> 2^N shift decoder, parameter N.
  - Instanced for the one-hot value of both in_code and the scan idx.
- Thermometer generation and the FSM/counters live in decoder_seq.

Test Plan (N=4, DWELL_W=8):
- Reset then idle: rst high for 2 cycles -> F=0x0000, out_valid=0, scan_wrap=0. Then accept mode 00, code 5 -> next cycle F=0x0020, out_valid=1; holds for 10 idle cycles.
- Thermometer edge cases: code 0 -> F=0x0001; code 7 -> 0x00FF; code 15 -> 0xFFFF.
- Scan: mode 10, code 14, dwell 2 -> F=0x4000 for 3 cycles, then 0x8000 for 3 cycles, then 0x0001 with scan_wrap=1 in that first cycle only. Repeat with dwell 0 -> the index advances every cycle.
- Enable freeze: during the scan above, drop en for 4 cycles mid-dwell -> F=0 one cycle later and in_ready=0, in_valid ignored. After en returns, F resumes at the same index, and the remaining dwell is unchanged.
- Pre-emption and clear: mid-scan, accept mode 00 code 3 -> next cycle F=0x0008, no further advance. Then accept mode 11 -> F=0, out_valid=0.
- Reset mid-scan: assert rst in the cycle of an index advance with in_valid=1 -> F=0, state IDLE, and the accept is discarded.
